read_resp_packetizer: RTL

- Sits directly downstream of the core read module.
- Accepts 31-bit core-read words, each with a 1-cycle valid strobe and a core ID tag.
- Buffers the words in a FIFO and serializes each one as a 2-beat packet (header, data) onto the PCIe TX stream.
- Uses a valid/ready handshake on the TX side, so host backpressure never stalls the read stage; overflow is dropped and counted.

---
 rtl/read_resp_packetizer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/read_resp_packetizer.sv
// Buffers core-read words and emits each as a 2-beat TX packet: {1,7'b0,core,seq} then {0,word}.
// Latency: word in cycle N -> header valid in N+2, data in N+3; one packet per 2 cycles sustained.
// Backpressure: TX valid/ready stalls only the FSM; the input never stalls, overflow is dropped and counted.

module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o = wr_ptr_q - rd_ptr_q;
endmodule

module read_resp_packetizer #(
    parameter int DEPTH  = 16,
    parameter int CORE_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [30:0]       in_data,
    input  logic              in_valid,
    input  logic [CORE_W-1:0] in_core,
    input  logic              flush,
    output logic [31:0]       tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CORE_W-1:0]   hold_core_q, hold_core_d;
    logic [30:0]         hold_word_q, hold_word_d;
    logic [CNT_W-1:0]    seq_q, seq_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;
    logic [31:0]         tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                tx_last_q, tx_last_d;

    logic [CORE_W+30:0]  fifo_rdata;
    logic [AW:0]         fifo_count;
    logic                full, empty;
    logic                push, pop, drop;
    logic [7:0]          hdr_core;
    logic [15:0]         hdr_seq;

    sync_fifo #(.DEPTH(DEPTH), .W(CORE_W + 31)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_core, in_data}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign full  = (fifo_count == DEPTH_C);
    assign empty = (fifo_count == '0);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        seq_d   = seq_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (tx_ready) state_d = DATA;
            end
            DATA: begin
                if (tx_ready) begin
                    seq_d = seq_q + CNT_W'(1);
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = HDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            pop     = 1'b0;
            state_d = IDLE;
        end

        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push = in_valid && !flush && (!full || pop);
        drop = in_valid && !flush && full && !pop;

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        overflow_d = overflow_q | drop;

        hold_core_d = pop ? fifo_rdata[CORE_W+30:31] : hold_core_q;
        hold_word_d = pop ? fifo_rdata[30:0]         : hold_word_q;

        hdr_core   = 8'(hold_core_d);
        hdr_seq    = 16'(seq_d);
        tx_data_d  = 32'h0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        case (state_d)
            HDR: begin
                tx_valid_d = 1'b1;
                tx_data_d  = {1'b1, 7'b0, hdr_core, hdr_seq};
            end
            DATA: begin
                tx_valid_d = 1'b1;
                tx_last_d  = 1'b1;
                tx_data_d  = {1'b0, hold_word_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_core_q <= '0;
            hold_word_q <= '0;
            seq_q       <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_core_q <= hold_core_d;
            hold_word_q <= hold_word_d;
            seq_q       <= seq_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_last    = tx_last_q;
    assign fifo_full  = full;
    assign fifo_empty = empty;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;
endmodule
